// File: rtl/count4_up.sv
//----------------------------------------------------------------------------
// Module      : count4_up
// Description : Up counter with enable, synchronous clear, parallel load and
//               a programmable wrap value. Every state bit is its own D
//               flip-flop, and the increment uses toggle logic. Combinational
//               terminal count (tc) and carry out (co) allow instances to be
//               cascaded into wider counters.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

// Single state bit: D flip-flop with asynchronous active-low clear.
module count4_up_dff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // State bit capture; reset forces 0 without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

module count4_up #(
  parameter int WIDTH = 4,
  parameter int MAX   = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co
);

  // Wrap value truncated to the counter width.
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

  logic [WIDTH-1:0] w_toggle;  // bit i toggles when all lower bits are 1
  logic [WIDTH-1:0] w_inc;     // q + 1 formed by toggling
  logic             w_wrap;    // at or above the wrap value
  logic [WIDTH-1:0] w_next;    // next state presented to the flip-flops

  // Toggle enables and the incremented value, one slice per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_toggle
    if (i == 0) begin : g_lsb
      assign w_toggle[i] = 1'b1;
    end else begin : g_upper
      assign w_toggle[i] = &q[i-1:0];
    end
    assign w_inc[i] = q[i] ^ w_toggle[i];
  end

  // Values loaded above the wrap value also wrap, so the counter never
  // walks through the unused range.
  assign w_wrap = (q >= c_max);

  // Next-state selection in priority order: clear, load, wrap, increment.
  always_comb begin
    w_next = q;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      w_next = d;
    end else if (en) begin
      if (w_wrap) begin
        w_next = '0;
      end else begin
        w_next = w_inc;
      end
    end
  end

  // One flip-flop per count bit; q comes straight from the flops.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    count4_up_dff u_dff (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (w_next[i]),
      .q       (q[i])
    );
  end

  // Terminal count and cascade carry, no register stage.
  assign tc = (q == c_max);
  assign co = tc & en;

endmodule

`default_nettype wire

// File: tb/tb_count4_up.sv
//----------------------------------------------------------------------------
// Module      : tb_count4_up
// Description : Self-checking bench for count4_up: default counter, a MAX=9
//               counter and a two-stage cascade, using scoreboard queues.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_count4_up;

  logic clk = 1'b0;
  always #1 clk = ~clk;

  logic reset_n;

  // Default-parameter counter
  logic       en, clr, load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, co;

  // MAX = 9 counter
  logic       en9, clr9, load9;
  logic [3:0] d9;
  logic [3:0] q9;
  logic       tc9, co9;

  // Two-stage cascade
  logic       cen, cclr, cload;
  logic [3:0] cd;
  logic [3:0] q0, q1;
  logic       tc0, tc1, co0, co1;

  int passed = 0;
  int total  = 0;

  logic [3:0] mq, mq9;
  logic [7:0] mc;
  logic [3:0] sb[$];
  logic [3:0] sb9[$];
  logic [7:0] sbc[$];

  count4_up dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
    .d(d), .q(q), .tc(tc), .co(co)
  );

  count4_up #(.WIDTH(4), .MAX(9)) dut9 (
    .clk(clk), .reset_n(reset_n), .en(en9), .clr(clr9), .load(load9),
    .d(d9), .q(q9), .tc(tc9), .co(co9)
  );

  count4_up u_c0 (
    .clk(clk), .reset_n(reset_n), .en(cen), .clr(cclr), .load(cload),
    .d(cd), .q(q0), .tc(tc0), .co(co0)
  );

  count4_up u_c1 (
    .clk(clk), .reset_n(reset_n), .en(co0), .clr(cclr), .load(cload),
    .d(cd), .q(q1), .tc(tc1), .co(co1)
  );

  // Reference next-state for a 4-bit counter with wrap value mx.
  function automatic logic [3:0] mdl(logic [3:0] cur, logic e, logic c,
                                     logic l, logic [3:0] dv, int mx);
    if (c) return 4'd0;
    if (l) return dv;
    if (e) return (int'(cur) >= mx) ? 4'd0 : 4'(int'(cur) + 1);
    return cur;
  endfunction

  // Apply inputs at a falling edge, queue the expected post-edge value.
  task automatic drive(input logic e, input logic c, input logic l,
                       input logic [3:0] dv);
    en = e; clr = c; load = l; d = dv;
    mq = mdl(mq, e, c, l, dv, 15);
    sb.push_back(mq);
    @(negedge clk);
  endtask

  task automatic drive9(input logic e, input logic c, input logic l,
                        input logic [3:0] dv);
    en9 = e; clr9 = c; load9 = l; d9 = dv;
    mq9 = mdl(mq9, e, c, l, dv, 9);
    sb9.push_back(mq9);
    @(negedge clk);
  endtask

  task automatic drivec(input logic e, input logic c);
    cen = e; cclr = c;
    if (c) mc = 8'd0;
    else if (e) mc = mc + 8'd1;
    sbc.push_back(mc);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    reset_n = 1'b0;
    en = 1'b1; clr = 1'b0; load = 1'b0; d = 4'd0;
    en9 = 1'b0; clr9 = 1'b0; load9 = 1'b0; d9 = 4'd0;
    cen = 1'b0; cclr = 1'b0; cload = 1'b0; cd = 4'd0;
    repeat (5) @(negedge clk);
    exp = 4'd0;
    total++;
    if (q !== exp) $display("FAIL reset_q: got %0h want %0h", q, exp);
    else passed++;
    total++;
    if (tc !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc);
    else passed++;
    total++;
    if (co !== 1'b0) $display("FAIL reset_co: got %b want 0", co);
    else passed++;
    reset_n = 1'b1;
    mq = 4'd0; mq9 = 4'd0; mc = 8'd0;
  endtask

  task automatic test_count();
    logic [3:0] exp;
    int         tc_hi;
    tc_hi = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      exp = sb.pop_front();
      total++;
      if (q !== exp) $display("FAIL count_q[%0d]: got %0d want %0d", i, q, exp);
      else passed++;
      total++;
      if (tc !== (exp == 4'd15)) $display("FAIL count_tc[%0d]: got %b want %b", i, tc, exp == 4'd15);
      else passed++;
      total++;
      if (co !== (exp == 4'd15)) $display("FAIL count_co[%0d]: got %b want %b", i, co, exp == 4'd15);
      else passed++;
      if (i < 16 && tc === 1'b1) tc_hi++;
    end
    total++;
    if (tc_hi !== 1) $display("FAIL count_tc_duty: got %0d want 1", tc_hi);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [3:0] exp;
    int         n;
    n = 0;
    while (mq != 4'd9 && n < 20) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      exp = sb.pop_front();
      total++;
      if (q !== exp) $display("FAIL arst_pre_q: got %0d want %0d", q, exp);
      else passed++;
      n++;
    end
    total++;
    if (q !== 4'd9) $display("FAIL arst_reach9: got %0d want 9", q);
    else passed++;
    en = 1'b0;
    reset_n = 1'b0;
    #0.25;
    total++;
    if (q !== 4'd0) $display("FAIL arst_immediate_q: got %0d want 0", q);
    else passed++;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    total++;
    if (q !== 4'd0) $display("FAIL arst_held_q: got %0d want 0", q);
    else passed++;
    total++;
    if (co !== 1'b0) $display("FAIL arst_held_co: got %b want 0", co);
    else passed++;
    reset_n = 1'b1;
    mq = 4'd0; mq9 = 4'd0; mc = 8'd0;
    sb.delete();
  endtask

  task automatic test_load_priority();
    logic [3:0] exp;
    drive(1'b0, 1'b0, 1'b1, 4'b1100);
    exp = sb.pop_front();
    total++;
    if (q !== exp) $display("FAIL load12: got %0d want %0d", q, exp);
    else passed++;
    drive(1'b0, 1'b1, 1'b1, 4'd5);
    exp = sb.pop_front();
    total++;
    if (q !== exp) $display("FAIL clr_over_load: got %0d want %0d", q, exp);
    else passed++;
    drive(1'b0, 1'b0, 1'b1, 4'd7);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'd3);
      exp = sb.pop_front();
      total++;
      if (q !== exp) $display("FAIL hold7[%0d]: got %0d want %0d", i, q, exp);
      else passed++;
    end
    drive(1'b0, 1'b0, 1'b1, 4'd15);
    exp = sb.pop_front();
    total++;
    if (q !== exp) $display("FAIL load15: got %0d want %0d", q, exp);
    else passed++;
    total++;
    if (tc !== 1'b1 || co !== 1'b0) $display("FAIL max_no_en: got tc=%b co=%b want tc=1 co=0", tc, co);
    else passed++;
    en = 1'b1;
    #0.25;
    total++;
    if (co !== 1'b1) $display("FAIL max_en_co: got %b want 1", co);
    else passed++;
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    exp = sb.pop_front();
    total++;
    if (q !== exp) $display("FAIL load_over_wrap: got %0d want %0d", q, exp);
    else passed++;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    void'(sb.pop_front());
  endtask

  task automatic test_wrap9();
    logic [3:0] exp;
    drive9(1'b0, 1'b1, 1'b0, 4'd0);
    void'(sb9.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive9(1'b1, 1'b0, 1'b0, 4'd0);
      exp = sb9.pop_front();
      total++;
      if (q9 !== exp) $display("FAIL wrap9_q[%0d]: got %0d want %0d", i, q9, exp);
      else passed++;
      total++;
      if (tc9 !== (exp == 4'd9)) $display("FAIL wrap9_tc[%0d]: got %b want %b", i, tc9, exp == 4'd9);
      else passed++;
    end
    drive9(1'b0, 1'b0, 1'b1, 4'd13);
    exp = sb9.pop_front();
    total++;
    if (q9 !== exp || tc9 !== 1'b0) $display("FAIL wrap9_load13: got q=%0d tc=%b want q=%0d tc=0", q9, tc9, exp);
    else passed++;
    drive9(1'b1, 1'b0, 1'b0, 4'd0);
    exp = sb9.pop_front();
    total++;
    if (q9 !== exp) $display("FAIL wrap9_above_max: got %0d want %0d", q9, exp);
    else passed++;
    en9 = 1'b0;
  endtask

  task automatic test_cascade();
    logic [7:0] exp;
    drivec(1'b0, 1'b1);
    void'(sbc.pop_front());
    for (int i = 0; i < 256; i++) begin
      drivec(1'b1, 1'b0);
      exp = sbc.pop_front();
      total++;
      if ({q1, q0} !== exp) $display("FAIL cascade_val[%0d]: got %02h want %02h", i, {q1, q0}, exp);
      else passed++;
      total++;
      if ((tc1 & tc0) !== (exp == 8'hFF)) $display("FAIL cascade_tc[%0d]: got %b want %b", i, tc1 & tc0, exp == 8'hFF);
      else passed++;
    end
    cen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_async_reset();
    test_load_priority();
    test_wrap9();
    test_cascade();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
